axis_pkt_s: RTL and testbench



---
 rtl/axis_pkt_s_pkg.sv | 23 ++
 rtl/axis_pkt_s_if.sv | 19 +
 rtl/axis_pkt_s_fifo_fwft.sv | 84 ++++++++
 rtl/axis_pkt_s.sv | 193 +++++++++++++++++++
 tb/tb_axis_pkt_s.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkt_s_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the axis_pkt_s packet receiver:
//   AXIS_DATA_W  - stream payload width
//   rx_state_e   - receive state machine states
//   axis_beat_t  - one FIFO entry: {last flag, payload}
// ---------------------------------------------------------------------------
package axis_pkg;

   localparam int AXIS_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IN_PKT = 2'd1,
      DROP   = 2'd2
   } rx_state_e;

   typedef struct packed {
      logic                   last;
      logic [AXIS_DATA_W-1:0] data;
   } axis_beat_t;

endpackage

// File: rtl/axis_pkt_s_if.sv
// ---------------------------------------------------------------------------
// axis_pkt_s_if
// AXI4-Stream beat channel between an upstream stream master and axis_pkt_s.
//   tvalid - beat valid        (master -> slave)
//   tready - slave can accept  (slave  -> master)
//   tdata  - beat payload      (master -> slave)
//   tlast  - final beat flag   (master -> slave)
// ---------------------------------------------------------------------------
interface axis_pkt_s_if;

   logic                            tvalid;
   logic                            tready;
   logic [axis_pkg::AXIS_DATA_W-1:0] tdata;
   logic                            tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/axis_pkt_s_fifo_fwft.sv
// ---------------------------------------------------------------------------
// axis_fifo_fwft
// First-word-fall-through FIFO of 2^DEPTH_LOG2 entries of type entry_t.
// The head entry is presented combinationally; it reads as zero when empty.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write wr_entry (ignored when full)
//   wr_entry    - entry to write
//   pop         - advance the head (ignored when empty)
//   rd_entry    - head entry
//   empty       - no entries stored
//   next_full   - occupancy after this edge will equal the depth
// ---------------------------------------------------------------------------
module axis_fifo_fwft
   import axis_pkg::*;
#(
   parameter int  DEPTH_LOG2 = 3,
   parameter type entry_t    = axis_beat_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  entry_t wr_entry,
   input  logic   pop,
   output entry_t rd_entry,
   output logic   empty,
   output logic   next_full
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   entry_t                mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [DEPTH_LOG2:0]   count_reg;
   logic [DEPTH_LOG2:0]   count_next;
   logic                  full;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count_reg == FULL_CNT);
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      count_next = count_reg;
      if (do_push && !do_pop) begin
         count_next = count_reg + 1'b1;
      end else if (!do_push && do_pop) begin
         count_next = count_reg - 1'b1;
      end
   end

   assign next_full = (count_next == FULL_CNT);

   // Storage has no reset; the head is masked while empty instead.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_entry;
      end
   end

   assign rd_entry = empty ? entry_t'('0) : mem[rd_ptr_reg];

   // Pointers wrap naturally at 2^DEPTH_LOG2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/axis_pkt_s.sv
// ---------------------------------------------------------------------------
// axis_pkt_s
// Buffered AXI4-Stream packet receiver. Accepted beats are queued with their
// tlast flag in a FWFT FIFO and drained through a valid/ready read port. A
// saturating beat counter reports each completed packet's length.
// Ports:
//   aclk, areset_n - clock, asynchronous active-low reset
//   s              - stream slave (tvalid/tready/tdata/tlast)
//   data, last     - FIFO head payload and tlast flag
//   valid, ready   - read port handshake (pop on valid && ready)
//   finish         - one-cycle pulse after a packet-ending beat is accepted
//   pkt_len        - beat count of the last completed packet
//   pkt_count      - completed packets since reset (16-bit, wraps)
//   len_err        - sticky over-length flag (AXIS_PKT_S_LEN_CHECK_EN only)
// Optional feature macro: AXIS_PKT_S_LEN_CHECK_EN truncates packets at
// MAX_BEATS beats and drops the remainder of the packet.
// ---------------------------------------------------------------------------
module axis_pkt_s
   import axis_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3,
   parameter int LEN_W      = 8,
   parameter int MAX_BEATS  = 16
) (
   input  logic                   aclk,
   input  logic                   areset_n,
   axis_pkt_s_if.slave            s,
   output logic [AXIS_DATA_W-1:0] data,
   output logic                   last,
   output logic                   valid,
   input  logic                   ready,
   output logic                   finish,
   output logic [LEN_W-1:0]       pkt_len,
   output logic [15:0]            pkt_count
`ifdef AXIS_PKT_S_LEN_CHECK_EN
   ,
   output logic                   len_err
`endif
);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_IN_PKT = IN_PKT;

   if (MAX_BEATS < 1 || MAX_BEATS > (1 << LEN_W) - 1) begin : g_bad_max_beats
      $error("MAX_BEATS must lie in 1 .. 2^LEN_W-1");
   end

   logic [1:0]       state_reg, state_next;
   logic [LEN_W-1:0] beat_cnt_reg, beat_cnt_next;
   logic [LEN_W-1:0] cnt_inc;
   logic [LEN_W-1:0] pkt_len_reg, pkt_len_next;
   logic [15:0]      pkt_count_reg, pkt_count_next;
   logic             finish_reg, finish_next;
   logic             tready_reg;
   logic             accept;
   logic             store;
   logic             trunc;
   logic             fifo_empty;
   logic             fifo_next_full;
   axis_beat_t       wr_entry;
   axis_beat_t       rd_entry;

   assign accept  = s.tvalid && tready_reg;
   assign s.tready = tready_reg;

   // Saturating increment: the beat counter never wraps.
   assign cnt_inc = (beat_cnt_reg == '1) ? beat_cnt_reg : beat_cnt_reg + 1'b1;

`ifdef AXIS_PKT_S_LEN_CHECK_EN
   localparam logic [1:0]       S_DROP  = DROP;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);

   logic             len_err_reg, len_err_next;
   logic [LEN_W-1:0] new_cnt;

   // Beat count including the beat being accepted now.
   assign new_cnt = (state_reg == S_IDLE) ? LEN_W'(1) : cnt_inc;
   // Beats of an over-length packet past the cut are accepted but discarded.
   assign store   = accept && (state_reg != S_DROP);
   assign len_err = len_err_reg;
`else
   assign store   = accept;
`endif

   always_comb begin
      state_next     = state_reg;
      beat_cnt_next  = beat_cnt_reg;
      finish_next    = 1'b0;
      pkt_len_next   = pkt_len_reg;
      pkt_count_next = pkt_count_reg;
      trunc          = 1'b0;
`ifdef AXIS_PKT_S_LEN_CHECK_EN
      len_err_next   = len_err_reg;
`endif
      if (accept) begin
         case (state_reg)
            S_IDLE: begin
               if (s.tlast) begin
                  finish_next    = 1'b1;
                  pkt_len_next   = LEN_W'(1);
                  pkt_count_next = pkt_count_reg + 16'd1;
               end else begin
                  state_next    = S_IN_PKT;
                  beat_cnt_next = LEN_W'(1);
               end
            end
            S_IN_PKT: begin
               if (s.tlast) begin
                  finish_next    = 1'b1;
                  pkt_len_next   = cnt_inc;
                  pkt_count_next = pkt_count_reg + 16'd1;
                  beat_cnt_next  = '0;
                  state_next     = S_IDLE;
               end else begin
                  beat_cnt_next = cnt_inc;
               end
            end
`ifdef AXIS_PKT_S_LEN_CHECK_EN
            S_DROP: begin
               if (s.tlast) begin
                  state_next = S_IDLE;
               end
            end
`endif
            default: state_next = S_IDLE;
         endcase
`ifdef AXIS_PKT_S_LEN_CHECK_EN
         // A non-final beat that reaches the limit closes the packet early:
         // it is stored as the last beat and the rest of the packet is dropped.
         if (state_reg != S_DROP && !s.tlast && new_cnt >= MAX_LEN) begin
            trunc          = 1'b1;
            finish_next    = 1'b1;
            pkt_len_next   = MAX_LEN;
            pkt_count_next = pkt_count_reg + 16'd1;
            beat_cnt_next  = '0;
            len_err_next   = 1'b1;
            state_next     = S_DROP;
         end
`endif
      end
   end

   assign wr_entry = '{last: s.tlast | trunc, data: s.tdata};

   axis_fifo_fwft #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .entry_t    (axis_beat_t)
   ) u_fifo (
      .clk       (aclk),
      .rst_n     (areset_n),
      .push      (store),
      .wr_entry  (wr_entry),
      .pop       (valid && ready),
      .rd_entry  (rd_entry),
      .empty     (fifo_empty),
      .next_full (fifo_next_full)
   );

   assign valid = !fifo_empty;
   assign data  = rd_entry.data;
   assign last  = rd_entry.last;

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_reg     <= S_IDLE;
         beat_cnt_reg  <= '0;
         pkt_len_reg   <= '0;
         pkt_count_reg <= '0;
         finish_reg    <= 1'b0;
         tready_reg    <= 1'b0;
`ifdef AXIS_PKT_S_LEN_CHECK_EN
         len_err_reg   <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         beat_cnt_reg  <= beat_cnt_next;
         pkt_len_reg   <= pkt_len_next;
         pkt_count_reg <= pkt_count_next;
         finish_reg    <= finish_next;
         // Registered from next-cycle occupancy: a pop that frees a full
         // FIFO raises tready one cycle later.
         tready_reg    <= !fifo_next_full;
`ifdef AXIS_PKT_S_LEN_CHECK_EN
         len_err_reg   <= len_err_next;
`endif
      end
   end

   assign finish    = finish_reg;
   assign pkt_len   = pkt_len_reg;
   assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_axis_pkt_s.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_s
// Self-checking bench for axis_pkt_s: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic compared cycle by cycle with a
// queue-based packet model. Honours AXIS_PKT_S_LEN_CHECK_EN when defined.
// ---------------------------------------------------------------------------
module tb_axis_pkt_s;
   import axis_pkg::*;

   localparam int DL    = 3;
   localparam int DEPTH = 1 << DL;
   localparam int LW    = 8;
   localparam int MAXB  = 4;

   logic          aclk     = 1'b0;
   logic          areset_n = 1'b1;
   logic [31:0]   data;
   logic          last;
   logic          valid;
   logic          ready    = 1'b0;
   logic          finish;
   logic [LW-1:0] pkt_len;
   logic [15:0]   pkt_count;
`ifdef AXIS_PKT_S_LEN_CHECK_EN
   logic          len_err;
`endif

   axis_pkt_s_if bus ();

   always #5 aclk = ~aclk;

   axis_pkt_s #(
      .DEPTH_LOG2 (DL),
      .LEN_W      (LW),
      .MAX_BEATS  (MAXB)
   ) dut (
      .aclk      (aclk),
      .areset_n  (areset_n),
      .s         (bus),
      .data      (data),
      .last      (last),
      .valid     (valid),
      .ready     (ready),
      .finish    (finish),
      .pkt_len   (pkt_len),
      .pkt_count (pkt_count)
`ifdef AXIS_PKT_S_LEN_CHECK_EN
      ,
      .len_err   (len_err)
`endif
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural packet model ----------------
   logic [32:0]   m_q[$];    // stored beats {last, data}
   bit            m_rdy;
   int            m_beats;   // beats seen in the current packet
   bit            m_drop;
   bit            m_fin;
   logic [LW-1:0] m_len;
   logic [15:0]   m_cnt;
   bit            m_err;

   task automatic model_reset();
      m_q.delete();
      m_rdy = 0; m_beats = 0; m_drop = 0; m_fin = 0;
      m_len = '0; m_cnt = '0; m_err = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".tready"}, bus.tready, m_rdy);
      chk({tag, ".valid"}, valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
         chk({tag, ".data"}, data, m_q[0][31:0]);
         chk({tag, ".last"}, last, m_q[0][32]);
      end
      chk({tag, ".finish"}, finish, m_fin);
      chk({tag, ".pkt_len"}, pkt_len, m_len);
      chk({tag, ".pkt_count"}, pkt_count, m_cnt);
`ifdef AXIS_PKT_S_LEN_CHECK_EN
      chk({tag, ".len_err"}, len_err, m_err);
`endif
   endtask

   // One clock: drive, step the model with the same inputs, compare.
   task automatic cycle(input bit tv, input logic [31:0] td, input bit tl,
                        input bit rd, output bit acc);
      bit pop;
      int n;
      bus.tvalid = tv; bus.tdata = td; bus.tlast = tl; ready = rd;
      acc = tv && m_rdy;
      pop = rd && (m_q.size() > 0);
      @(posedge aclk); #1;
      m_fin = 0;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
         if (m_drop) begin
            if (tl) m_drop = 0;
         end else begin
            n = m_beats + 1;
`ifdef AXIS_PKT_S_LEN_CHECK_EN
            if (!tl && n >= MAXB) begin
               m_q.push_back({1'b1, td});
               m_fin = 1; m_len = LW'(MAXB); m_cnt++;
               m_beats = 0; m_drop = 1; m_err = 1;
            end else
`endif
            begin
               m_q.push_back({tl, td});
               if (tl) begin
                  m_fin = 1; m_len = LW'((n > 255) ? 255 : n); m_cnt++; m_beats = 0;
               end else begin
                  m_beats = n;
               end
            end
         end
      end
      m_rdy = m_q.size() < DEPTH;
      if (m_fin) $display("packet %0d complete, len %0d", m_cnt, m_len);
      check_all("cyc");
   endtask

   task automatic do_reset();
      bus.tvalid = 0; bus.tdata = '0; bus.tlast = 0; ready = 0;
      #2 areset_n = 1'b0;
      #1;
      chk("rst.tready", bus.tready, 0);
      chk("rst.valid", valid, 0);
      chk("rst.finish", finish, 0);
      chk("rst.pkt_len", pkt_len, 0);
      chk("rst.pkt_count", pkt_count, 0);
      chk("rst.data", {last, data}, 0);
      model_reset();
      @(posedge aclk); @(posedge aclk); #1;
      areset_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      bit acc;
      for (int c = 0; c < 3 * DEPTH && m_q.size() > 0; c++) cycle(0, '0, 0, 1, acc);
      chk({tag, ".drained"}, valid, 0);
   endtask

   typedef struct {
      bit tv; logic [31:0] td; bit tl; bit rd;
      bit e_rdy; bit e_valid; logic [31:0] e_data; bit e_last;
      bit e_fin; logic [LW-1:0] e_len; logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #300_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int b, fins, pops, i;

      tbl[0] = '{0, 32'h0,        0, 0, 1, 0, 32'h0,        0, 0, 0, 0};
      tbl[1] = '{1, 32'hAAAABBBB, 1, 1, 1, 1, 32'hAAAABBBB, 1, 1, 1, 1};
      tbl[2] = '{0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 1, 1};
      tbl[3] = '{1, 32'h11,       0, 0, 1, 1, 32'h11,       0, 0, 1, 1};
      tbl[4] = '{1, 32'h22,       1, 1, 1, 1, 32'h22,       1, 1, 2, 2};
      tbl[5] = '{0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 2, 2};

      // ---- reset + directed table ----
      #1;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         bus.tvalid = tbl[k].tv; bus.tdata = tbl[k].td; bus.tlast = tbl[k].tl;
         ready = tbl[k].rd;
         @(posedge aclk); #1;
         chk($sformatf("vec%0d.tready", k), bus.tready, tbl[k].e_rdy);
         chk($sformatf("vec%0d.valid", k), valid, tbl[k].e_valid);
         if (tbl[k].e_valid) begin
            chk($sformatf("vec%0d.data", k), data, tbl[k].e_data);
            chk($sformatf("vec%0d.last", k), last, tbl[k].e_last);
         end
         chk($sformatf("vec%0d.finish", k), finish, tbl[k].e_fin);
         chk($sformatf("vec%0d.pkt_len", k), pkt_len, tbl[k].e_len);
         chk($sformatf("vec%0d.pkt_count", k), pkt_count, tbl[k].e_cnt);
         $display("vector %0d: tvalid=%0d tdata=%h tlast=%0d ready=%0d", k,
                  tbl[k].tv, tbl[k].td, tbl[k].tl, tbl[k].rd);
      end

`ifndef AXIS_PKT_S_LEN_CHECK_EN
      // ---- 10-beat packet into an 8-deep FIFO ----
      do_reset();
      b = 0;
      for (int c = 0; c < 20; c++) begin
         cycle(1, 32'(b), b == 9, 0, acc);
         if (acc) b++;
      end
      chk("burst.fill_accepts", b, 8);
      chk("burst.tready_low", bus.tready, 0);
      for (int c = 0; c < 40 && (b < 10 || m_q.size() > 0); c++) begin
         cycle(b < 10, 32'(b), b == 9, 1, acc);
         if (acc) b++;
      end
      chk("burst.accepts", b, 10);
      chk("burst.pkt_len", pkt_len, 10);
      chk("burst.valid_end", valid, 0);
`endif

      // ---- reset in the middle of a packet ----
      do_reset();
      b = 0;
      for (int c = 0; c < 10 && b < 3; c++) begin
         cycle(1, 32'h40 + 32'(b), 0, 0, acc);
         if (acc) b++;
      end
      do_reset();
      b = 0;
      for (int c = 0; c < 10 && b < 2; c++) begin
         cycle(1, 32'h50 + 32'(b), b == 1, 1, acc);
         if (acc) b++;
      end
      drain("midrst");
      chk("midrst.pkt_len", pkt_len, 2);
      chk("midrst.pkt_count", pkt_count, 1);

      // ---- continuous tvalid, ready toggling ----
      do_reset();
      i = 0;
      for (int c = 0; c < 300; c++) begin
         cycle(1, 32'hCCCCDDDD + 32'(i), $urandom_range(0, 4) == 0, c[0], acc);
         if (acc) i++;
      end
      drain("stream");

      // ---- fully random traffic ----
      do_reset();
      for (int c = 0; c < 400; c++) begin
         cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 5) == 0,
               $urandom_range(0, 2) != 0, acc);
      end
      drain("random");

`ifdef AXIS_PKT_S_LEN_CHECK_EN
      // ---- over-length packet: truncated at MAX_BEATS ----
      do_reset();
      b = 0; fins = 0; pops = 0;
      for (int c = 0; c < 20 && b < 6; c++) begin
         cycle(1, 32'h100 + 32'(b), b == 5, 0, acc);
         if (acc) b++;
         if (finish) fins++;
      end
      chk("trunc.len_err", len_err, 1);
      chk("trunc.pkt_len", pkt_len, MAXB);
      for (int c = 0; c < 20 && valid; c++) begin
         pops++;
         cycle(0, '0, 0, 1, acc);
         if (finish) fins++;
      end
      chk("trunc.stored", pops, MAXB);
      chk("trunc.finishes", fins, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
